// File: rtl/pitch_ratio_sequencer.sv
// pitch_ratio_sequencer: clamps the per-frame semitone shift, looks up 2^(k/12) in Q2.14
// and slews the applied ratio toward it, offering each new ratio over valid/ready.
module pitch_ratio_sequencer #(
    parameter int unsigned MAX_STEP = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  shift_amt,
    input  logic        frame_start,
    output logic [15:0] ratio,
    output logic        ratio_valid,
    input  logic        ratio_ready,
    output logic        clamped,
    output logic        frame_overrun
);
    typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE, PRESENT} state_t;
    localparam logic [16:0] STEP = 17'(MAX_STEP);
    state_t state, state_nx;
    logic [4:0] k, k_nx, idx;
    logic [15:0] target, rom_val, ratio_nx;
    logic signed [16:0] diff;
    logic [16:0] mag;
    logic accept, drop, load_target, load_ratio, done, changed, out_of_range;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state == IDLE   ? (frame_start ? LOOKUP : IDLE) :
                   state == LOOKUP ? UPDATE :
                   state == UPDATE ? (changed ? PRESENT : IDLE) :
                                     (ratio_ready ? IDLE : PRESENT);
    end
    always_comb begin
        accept      = state == IDLE && frame_start;
        drop        = state != IDLE && frame_start;
        load_target = state == LOOKUP;
        load_ratio  = state == UPDATE;
        done        = state == PRESENT && ratio_ready;
    end
    // k is kept as 5-bit two's complement; adding 12 wraps -12..+12 onto 0..24
    always_comb begin
        out_of_range = $signed(shift_amt) > 8'sd12 || $signed(shift_amt) < -8'sd12;
        k_nx = $signed(shift_amt) > 8'sd12 ? 5'd12 :
               $signed(shift_amt) < -8'sd12 ? 5'd20 : shift_amt[4:0];
        idx = k + 5'd12;
    end
    always_comb begin
        rom_val = 16'd16384;
        case (idx)
            5'd0:  rom_val = 16'd8192;
            5'd1:  rom_val = 16'd8679;
            5'd2:  rom_val = 16'd9195;
            5'd3:  rom_val = 16'd9742;
            5'd4:  rom_val = 16'd10321;
            5'd5:  rom_val = 16'd10935;
            5'd6:  rom_val = 16'd11585;
            5'd7:  rom_val = 16'd12274;
            5'd8:  rom_val = 16'd13004;
            5'd9:  rom_val = 16'd13777;
            5'd10: rom_val = 16'd14596;
            5'd11: rom_val = 16'd15464;
            5'd12: rom_val = 16'd16384;
            5'd13: rom_val = 16'd17358;
            5'd14: rom_val = 16'd18390;
            5'd15: rom_val = 16'd19484;
            5'd16: rom_val = 16'd20643;
            5'd17: rom_val = 16'd21870;
            5'd18: rom_val = 16'd23170;
            5'd19: rom_val = 16'd24548;
            5'd20: rom_val = 16'd26008;
            5'd21: rom_val = 16'd27554;
            5'd22: rom_val = 16'd29193;
            5'd23: rom_val = 16'd30929;
            5'd24: rom_val = 16'd32768;
            default: rom_val = 16'd16384;
        endcase
    end
    // the step never crosses target, so 16-bit add/subtract cannot wrap
    always_comb begin
        diff     = $signed({1'b0, target}) - $signed({1'b0, ratio});
        mag      = diff[16] ? $unsigned(-diff) : $unsigned(diff);
        ratio_nx = mag <= STEP ? target :
                   diff[16] ? ratio - STEP[15:0] : ratio + STEP[15:0];
        changed  = ratio_nx != ratio;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k             <= 5'd0;
            target        <= 16'd16384;
            ratio         <= 16'd16384;
            ratio_valid   <= 1'b0;
            clamped       <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            if (accept) k <= k_nx;
            if (accept) clamped <= out_of_range;
            if (drop) frame_overrun <= 1'b1;
            if (load_target) target <= rom_val;
            if (load_ratio) ratio <= ratio_nx;
            if (load_ratio && changed) ratio_valid <= 1'b1;
            else if (done) ratio_valid <= 1'b0;
        end
    end
endmodule
